// File: rtl/eh2_dccm_req_arb.sv
// Arbitrates the single DCCM port between the LSU (fixed priority) and the DMA slave.
// A saturating starvation counter forces one DMA grant after MAX_WAIT consecutive denials.
module eh2_dccm_req_arb #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int MAX_WAIT         = 4
) (
    input  logic                        clk,
    input  logic                        rst_l,

    input  logic                        lsu_req_valid,
    input  logic                        lsu_req_write,
    input  logic [DCCM_BITS-1:0]        lsu_req_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] lsu_req_wdata,
    output logic                        lsu_req_ready,

    input  logic                        dma_req_valid,
    input  logic                        dma_req_write,
    input  logic [DCCM_BITS-1:0]        dma_req_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] dma_req_wdata,
    output logic                        dma_req_ready,

    output logic                        lsu_rd_valid,
    output logic [DCCM_FDATA_WIDTH-1:0] lsu_rd_data,
    output logic                        dma_rd_valid,
    output logic [DCCM_FDATA_WIDTH-1:0] dma_rd_data,

    output logic                        dccm_wren,
    output logic                        dccm_rden,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data,

    output logic [3:0]                  dma_wait_cnt
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       rd_pend_q,  rd_pend_d;
    logic       rd_owner_q, rd_owner_d;

    logic                        grant_lsu, grant_dma, grant_any;
    logic                        win_write;
    logic [DCCM_BITS-1:0]        win_addr;
    logic [DCCM_FDATA_WIDTH-1:0] win_wdata;

    always_comb begin
        grant_dma = dma_req_valid & (~lsu_req_valid | (wait_cnt_q == MAX_WAIT_C));
        grant_lsu = lsu_req_valid & ~grant_dma;
        grant_any = grant_lsu | grant_dma;
    end

    // Winner's request; everything is zero when nothing is granted so the buses never float.
    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (grant_dma) begin
            win_write = dma_req_write;
            win_addr  = dma_req_addr;
            win_wdata = dma_req_wdata;
        end else if (grant_lsu) begin
            win_write = lsu_req_write;
            win_addr  = lsu_req_addr;
            win_wdata = lsu_req_wdata;
        end
    end

    assign lsu_req_ready = grant_lsu;
    assign dma_req_ready = grant_dma;

    assign dccm_wren    = grant_any &  win_write;
    assign dccm_rden    = grant_any & ~win_write;
    assign dccm_wr_addr = win_addr;
    assign dccm_rd_addr = win_addr;
    assign dccm_wr_data = win_wdata;

    always_comb begin
        wait_cnt_d = 4'd0;
        if (dma_req_valid && !grant_dma) begin
            wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 4'd1;
        end
        rd_pend_d  = dccm_rden;
        rd_owner_d = dccm_rden ? grant_dma : rd_owner_q;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wait_cnt_q <= 4'd0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Read data flows straight from the macro to whichever requester issued last cycle's read.
    assign lsu_rd_valid = rd_pend_q & ~rd_owner_q;
    assign dma_rd_valid = rd_pend_q &  rd_owner_q;
    assign lsu_rd_data  = lsu_rd_valid ? dccm_rd_data : '0;
    assign dma_rd_data  = dma_rd_valid ? dccm_rd_data : '0;
    assign dma_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_eh2_dccm_req_arb.sv
// Directed bench for eh2_dccm_req_arb: arbitration, starvation counter, read return and reset.
module tb_eh2_dccm_req_arb;

    localparam int AW = 16;
    localparam int DW = 39;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          lsu_req_valid, lsu_req_write, lsu_req_ready;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_req_wdata;
    logic          dma_req_valid, dma_req_write, dma_req_ready;
    logic [AW-1:0] dma_req_addr;
    logic [DW-1:0] dma_req_wdata;
    logic          lsu_rd_valid, dma_rd_valid;
    logic [DW-1:0] lsu_rd_data, dma_rd_data;
    logic          dccm_wren, dccm_rden;
    logic [AW-1:0] dccm_wr_addr, dccm_rd_addr;
    logic [DW-1:0] dccm_wr_data, dccm_rd_data;
    logic [3:0]    dma_wait_cnt;

    int checks = 0;
    int errors = 0;

    eh2_dccm_req_arb #(.DCCM_BITS(AW), .DCCM_FDATA_WIDTH(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_l(rst_l),
        .lsu_req_valid(lsu_req_valid), .lsu_req_write(lsu_req_write),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_ready(lsu_req_ready),
        .dma_req_valid(dma_req_valid), .dma_req_write(dma_req_write),
        .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata), .dma_req_ready(dma_req_ready),
        .lsu_rd_valid(lsu_rd_valid), .lsu_rd_data(lsu_rd_data),
        .dma_rd_valid(dma_rd_valid), .dma_rd_data(dma_rd_data),
        .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
        .dccm_wr_addr(dccm_wr_addr), .dccm_rd_addr(dccm_rd_addr),
        .dccm_wr_data(dccm_wr_data), .dccm_rd_data(dccm_rd_data),
        .dma_wait_cnt(dma_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lsu_req_valid = 1'b0; lsu_req_write = 1'b0; lsu_req_addr = '0; lsu_req_wdata = '0;
        dma_req_valid = 1'b0; dma_req_write = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
    endtask

    initial begin
        idle();
        dccm_rd_data = '0;
        rst_l = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_wait_cnt", dma_wait_cnt, 0);
        check("rst_lsu_rd_valid", lsu_rd_valid, 0);
        check("rst_dma_rd_valid", dma_rd_valid, 0);
        check("rst_wren", dccm_wren, 0);
        check("rst_rden", dccm_rden, 0);
        check("rst_rd_addr", dccm_rd_addr, 0);
        check("rst_wr_data", dccm_wr_data, 0);
        rst_l = 1'b1;
        tick();

        // LSU read, DMA idle
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 16'h0040;
        #1;
        check("t1_lsu_ready", lsu_req_ready, 1);
        check("t1_dma_ready", dma_req_ready, 0);
        check("t1_rden", dccm_rden, 1);
        check("t1_wren", dccm_wren, 0);
        check("t1_rd_addr", dccm_rd_addr, 16'h0040);
        tick();
        idle();
        dccm_rd_data = 39'h55_AABB_CCDD;
        #1;
        check("t1_lsu_rd_valid", lsu_rd_valid, 1);
        check("t1_lsu_rd_data", lsu_rd_data, 39'h55_AABB_CCDD);
        check("t1_dma_rd_valid", dma_rd_valid, 0);
        check("t1_dma_rd_data", dma_rd_data, 0);
        check("t1_idle_rden", dccm_rden, 0);
        tick();

        // DMA write, LSU idle
        dma_req_valid = 1'b1; dma_req_write = 1'b1; dma_req_addr = 16'h0100; dma_req_wdata = 39'h12345678;
        #1;
        check("t2_dma_ready", dma_req_ready, 1);
        check("t2_wren", dccm_wren, 1);
        check("t2_rden", dccm_rden, 0);
        check("t2_wr_addr", dccm_wr_addr, 16'h0100);
        check("t2_wr_data", dccm_wr_data, 39'h12345678);
        check("t2_lsu_rd_valid", lsu_rd_valid, 0);
        tick();
        idle();
        #1;
        check("t2_wait_cnt", dma_wait_cnt, 0);
        check("t2_dma_rd_valid", dma_rd_valid, 0);
        check("t2_idle_wr_addr", dccm_wr_addr, 0);
        tick();

        // Both held valid: four LSU grants then one forced DMA grant, repeating
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 16'h0010;
        dma_req_valid = 1'b1; dma_req_write = 1'b1; dma_req_addr = 16'h0020; dma_req_wdata = 39'h7F_0000_0001;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("t3_wait_cnt_c%0d", k), dma_wait_cnt, k % 5);
            check($sformatf("t3_dma_ready_c%0d", k), dma_req_ready, (k % 5) == 4);
            check($sformatf("t3_lsu_ready_c%0d", k), lsu_req_ready, (k % 5) != 4);
            if ((k % 5) == 4) begin
                check($sformatf("t3_wren_c%0d", k), dccm_wren, 1);
                check($sformatf("t3_wr_addr_c%0d", k), dccm_wr_addr, 16'h0020);
                check($sformatf("t3_wr_data_c%0d", k), dccm_wr_data, 39'h7F_0000_0001);
            end else begin
                check($sformatf("t3_rden_c%0d", k), dccm_rden, 1);
                check($sformatf("t3_rd_addr_c%0d", k), dccm_rd_addr, 16'h0010);
                check($sformatf("t3_wr_addr_follow_c%0d", k), dccm_wr_addr, 16'h0010);
            end
            tick();
        end
        idle();
        #1;
        check("t3_wait_cleared", dma_wait_cnt, 0);
        tick();

        // Alternating reads LSU, DMA, LSU: no bubble, no cross-delivery
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 16'h0030;
        #1;
        check("t4_r0_lsu_ready", lsu_req_ready, 1);
        tick();
        idle();
        dma_req_valid = 1'b1; dma_req_write = 1'b0; dma_req_addr = 16'h0031;
        dccm_rd_data = 39'h01_1111_1111;
        #1;
        check("t4_r1_dma_ready", dma_req_ready, 1);
        check("t4_r1_rd_addr", dccm_rd_addr, 16'h0031);
        check("t4_r1_lsu_rd_valid", lsu_rd_valid, 1);
        check("t4_r1_lsu_rd_data", lsu_rd_data, 39'h01_1111_1111);
        check("t4_r1_dma_rd_valid", dma_rd_valid, 0);
        tick();
        idle();
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 16'h0032;
        dccm_rd_data = 39'h02_2222_2222;
        #1;
        check("t4_r2_lsu_ready", lsu_req_ready, 1);
        check("t4_r2_dma_rd_valid", dma_rd_valid, 1);
        check("t4_r2_dma_rd_data", dma_rd_data, 39'h02_2222_2222);
        check("t4_r2_lsu_rd_valid", lsu_rd_valid, 0);
        check("t4_r2_lsu_rd_data", lsu_rd_data, 0);
        tick();
        idle();
        dccm_rd_data = 39'h03_3333_3333;
        #1;
        check("t4_r3_lsu_rd_valid", lsu_rd_valid, 1);
        check("t4_r3_lsu_rd_data", lsu_rd_data, 39'h03_3333_3333);
        check("t4_r3_dma_rd_valid", dma_rd_valid, 0);
        tick();
        check("t4_r4_lsu_rd_valid", lsu_rd_valid, 0);
        check("t4_r4_dma_rd_valid", dma_rd_valid, 0);

        // DMA drops after two denials: counter restarts, four fresh denials needed
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 16'h0050;
        dma_req_valid = 1'b1; dma_req_write = 1'b1; dma_req_addr = 16'h0060; dma_req_wdata = 39'h0A;
        #1;
        check("t5_deny0_dma_ready", dma_req_ready, 0);
        tick();
        check("t5_deny1_dma_ready", dma_req_ready, 0);
        check("t5_deny1_wait", dma_wait_cnt, 1);
        tick();
        dma_req_valid = 1'b0;
        #1;
        check("t5_drop_wait", dma_wait_cnt, 2);
        tick();
        check("t5_after_drop_wait", dma_wait_cnt, 0);
        dma_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t5_re_wait_c%0d", k), dma_wait_cnt, k);
            check($sformatf("t5_re_dma_ready_c%0d", k), dma_req_ready, k == 4);
            check($sformatf("t5_re_lsu_ready_c%0d", k), lsu_req_ready, k != 4);
            tick();
        end

        // Reset asserted while a read return is pending
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 16'h0070;
        dma_req_valid = 1'b1;
        #1;
        check("t6_lsu_ready", lsu_req_ready, 1);
        tick();
        idle();
        dccm_rd_data = 39'h44_4444_4444;
        #1;
        check("t6_pend_lsu_rd_valid", lsu_rd_valid, 1);
        check("t6_pend_wait", dma_wait_cnt, 1);
        rst_l = 1'b0;
        #1;
        check("t6_rst_lsu_rd_valid", lsu_rd_valid, 0);
        check("t6_rst_lsu_rd_data", lsu_rd_data, 0);
        check("t6_rst_wait", dma_wait_cnt, 0);
        tick();
        tick();
        rst_l = 1'b1;
        tick();
        check("t6_post_lsu_rd_valid", lsu_rd_valid, 0);
        check("t6_post_dma_rd_valid", dma_rd_valid, 0);
        check("t6_post_wren", dccm_wren, 0);
        check("t6_post_rden", dccm_rden, 0);
        check("t6_post_wait", dma_wait_cnt, 0);
        check("t6_post_lsu_ready", lsu_req_ready, 0);
        check("t6_post_dma_ready", dma_req_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
